n2_mu_dispatch: RTL and testbench

Issue-side controller for the two-issue core's multiply/divide unit. It sits between the second decode stage and the MU.
- Buffers MU-class micro-ops in a small queue.
- Issues them to the MU one at a time, with single outstanding op.
- Matches returning results by uid.
- Presents completed results to writeback through a valid/ready buffer.
The MU itself has no backpressure, so this block guarantees that every returned result has a free landing slot.

---
 rtl/n2_mu_dispatch.sv | 190 +++++++++++++++++++
 tb/tb_n2_mu_dispatch.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n2_mu_dispatch.sv
// Issue-side controller for the multiply/divide unit: queues MU uops, issues one at a time,
// matches returning results by uid and buffers them for writeback.
module n2_mu_dispatch #(
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned REGIDX_BITS = 5,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [7:0]             in_op_i,
    input  logic [7:0]             in_uid_i,
    input  logic [REGIDX_BITS-1:0] in_rd_i,
    input  logic [31:0]            in_rs1_i,
    input  logic [31:0]            in_rs2_i,
    input  logic                   flush_i,
    output logic                   mu_v_o,
    output logic [7:0]             mu_op_o,
    output logic [7:0]             mu_uid_o,
    output logic [REGIDX_BITS-1:0] mu_rd_o,
    output logic [31:0]            mu_rs1_o,
    output logic [31:0]            mu_rs2_o,
    input  logic                   mu_we_i,
    input  logic [7:0]             mu_uid_i,
    input  logic [31:0]            mu_rst_i,
    input  logic [REGIDX_BITS-1:0] mu_dst_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [7:0]             wb_uid_o,
    output logic [REGIDX_BITS-1:0] wb_rd_o,
    output logic [31:0]            wb_data_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned QAW = $clog2(QDEPTH);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWaitMul, StWaitDiv} state_e;

    // Input queue
    logic [7:0]             q_op_q  [QDEPTH];
    logic [7:0]             q_uid_q [QDEPTH];
    logic [REGIDX_BITS-1:0] q_rd_q  [QDEPTH];
    logic [31:0]            q_rs1_q [QDEPTH];
    logic [31:0]            q_rs2_q [QDEPTH];
    logic [QAW-1:0]         q_wptr_q, q_rptr_q;
    logic [QAW:0]           q_cnt_q;
    logic                   q_full, q_empty;

    // Result buffer
    logic [7:0]             rb_uid_q  [2];
    logic [REGIDX_BITS-1:0] rb_rd_q   [2];
    logic [31:0]            rb_data_q [2];
    logic                   rb_head_q;
    logic [1:0]             rb_cnt_q;
    logic                   rb_tail;

    state_e                 state_q;
    logic                   mu_v_q;
    logic [7:0]             mu_op_q, mu_uid_q, out_uid_q;
    logic [REGIDX_BITS-1:0] mu_rd_q;
    logic [31:0]            mu_rs1_q, mu_rs2_q;
    logic [WDW-1:0]         wd_q;
    logic                   err_q;

    logic in_fire, op_ok, q_push, bad_op;
    logic waiting, wb_pop, rb_room, issue;
    logic res_match, res_bad, timeout;

    assign q_full  = (q_cnt_q == (QAW + 1)'(QDEPTH));
    assign q_empty = (q_cnt_q == '0);

    assign in_ready_o = !q_full;
    assign in_fire    = in_valid_i && in_ready_o;
    assign op_ok      = $onehot(in_op_i);
    assign q_push     = in_fire && op_ok && !flush_i;
    assign bad_op     = in_fire && !op_ok;

    assign waiting = (state_q != StIdle);
    assign wb_pop  = wb_valid_o && wb_ready_i;
    // A result can only land after issue, so reserving a slot at issue time is enough.
    assign rb_room = ((rb_cnt_q - 2'(wb_pop)) <= 2'd1);
    assign issue   = (state_q == StIdle) && !q_empty && rb_room && !flush_i;

    assign res_match = waiting && mu_we_i && (mu_uid_i == out_uid_q);
    assign res_bad   = mu_we_i && !res_match;
    assign timeout   = waiting && !res_match && (wd_q == WDW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_wptr_q <= '0;
            q_rptr_q <= '0;
            q_cnt_q  <= '0;
        end else if (flush_i) begin
            q_wptr_q <= '0;
            q_rptr_q <= '0;
            q_cnt_q  <= '0;
        end else begin
            if (q_push) q_wptr_q <= q_wptr_q + QAW'(1);
            if (issue)  q_rptr_q <= q_rptr_q + QAW'(1);
            q_cnt_q <= q_cnt_q + (QAW + 1)'(q_push) - (QAW + 1)'(issue);
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_op_q[q_wptr_q]  <= in_op_i;
            q_uid_q[q_wptr_q] <= in_uid_i;
            q_rd_q[q_wptr_q]  <= in_rd_i;
            q_rs1_q[q_wptr_q] <= in_rs1_i;
            q_rs2_q[q_wptr_q] <= in_rs2_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            mu_v_q    <= 1'b0;
            mu_op_q   <= '0;
            mu_uid_q  <= '0;
            mu_rd_q   <= '0;
            mu_rs1_q  <= '0;
            mu_rs2_q  <= '0;
            out_uid_q <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            mu_v_q <= issue;
            err_q  <= bad_op || res_bad || timeout;
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        mu_op_q   <= q_op_q[q_rptr_q];
                        mu_uid_q  <= q_uid_q[q_rptr_q];
                        mu_rd_q   <= q_rd_q[q_rptr_q];
                        mu_rs1_q  <= q_rs1_q[q_rptr_q];
                        mu_rs2_q  <= q_rs2_q[q_rptr_q];
                        out_uid_q <= q_uid_q[q_rptr_q];
                        wd_q      <= '0;
                        state_q   <= (q_op_q[q_rptr_q][7:4] != 4'd0) ? StWaitMul : StWaitDiv;
                    end
                end
                default: begin
                    wd_q <= wd_q + WDW'(1);
                    if (res_match || timeout) state_q <= StIdle;
                end
            endcase
        end
    end

    assign rb_tail = rb_head_q ^ rb_cnt_q[0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rb_head_q <= 1'b0;
            rb_cnt_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                rb_uid_q[i]  <= '0;
                rb_rd_q[i]   <= '0;
                rb_data_q[i] <= '0;
            end
        end else begin
            if (res_match) begin
                rb_uid_q[rb_tail]  <= mu_uid_i;
                rb_rd_q[rb_tail]   <= mu_dst_i;
                rb_data_q[rb_tail] <= mu_rst_i;
            end
            if (wb_pop) rb_head_q <= ~rb_head_q;
            rb_cnt_q <= rb_cnt_q + 2'(res_match) - 2'(wb_pop);
        end
    end

    assign mu_v_o   = mu_v_q;
    assign mu_op_o  = mu_op_q;
    assign mu_uid_o = mu_uid_q;
    assign mu_rd_o  = mu_rd_q;
    assign mu_rs1_o = mu_rs1_q;
    assign mu_rs2_o = mu_rs2_q;

    assign wb_valid_o = (rb_cnt_q != 2'd0);
    assign wb_uid_o   = rb_uid_q[rb_head_q];
    assign wb_rd_o    = rb_rd_q[rb_head_q];
    assign wb_data_o  = rb_data_q[rb_head_q];

    assign busy_o = waiting || !q_empty;
    assign err_o  = err_q;

endmodule

// File: tb/tb_n2_mu_dispatch.sv
// Directed bench for n2_mu_dispatch with a small MU model answering two cycles after issue.
module tb_n2_mu_dispatch;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid_i, in_ready_o, flush_i;
    logic [7:0]    in_op_i, in_uid_i;
    logic [RW-1:0] in_rd_i;
    logic [31:0]   in_rs1_i, in_rs2_i;
    logic          mu_v_o;
    logic [7:0]    mu_op_o, mu_uid_o;
    logic [RW-1:0] mu_rd_o;
    logic [31:0]   mu_rs1_o, mu_rs2_o;
    logic          mu_we_i;
    logic [7:0]    mu_uid_i;
    logic [31:0]   mu_rst_i;
    logic [RW-1:0] mu_dst_i;
    logic          wb_valid_o, wb_ready_i;
    logic [7:0]    wb_uid_o;
    logic [RW-1:0] wb_rd_o;
    logic [31:0]   wb_data_o;
    logic          busy_o, err_o;

    n2_mu_dispatch #(.QDEPTH(4), .REGIDX_BITS(RW), .TIMEOUT(64)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
        .in_uid_i(in_uid_i), .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .flush_i(flush_i),
        .mu_v_o(mu_v_o), .mu_op_o(mu_op_o), .mu_uid_o(mu_uid_o), .mu_rd_o(mu_rd_o),
        .mu_rs1_o(mu_rs1_o), .mu_rs2_o(mu_rs2_o),
        .mu_we_i(mu_we_i), .mu_uid_i(mu_uid_i), .mu_rst_i(mu_rst_i), .mu_dst_i(mu_dst_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_uid_o(wb_uid_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // MU model state
    bit            mu_auto = 1'b0;
    int            pend_cnt = 0;
    logic [7:0]    pend_uid;
    logic [RW-1:0] pend_rd;
    logic [31:0]   pend_data;
    bit            inj_req = 1'b0;
    logic [7:0]    inj_uid;
    logic [RW-1:0] inj_rd;
    logic [31:0]   inj_data;

    // Activity logs
    int         issue_cnt = 0;
    logic [7:0] iss_op_q[$];
    int         iss_cyc_q[$];
    int         res_cyc_q[$];
    logic [7:0] wbu_q[$];
    logic [31:0] wbd_q[$];

    function automatic logic [31:0] mu_calc(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            8'h80:   return a * b;
            8'h04:   return (b == 0) ? 32'hffff_ffff : a / b;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        mu_we_i = 1'b0;
        if (inj_req) begin
            mu_we_i = 1'b1; mu_uid_i = inj_uid; mu_dst_i = inj_rd; mu_rst_i = inj_data;
            inj_req = 1'b0;
        end else if (pend_cnt == 1) begin
            mu_we_i = 1'b1; mu_uid_i = pend_uid; mu_dst_i = pend_rd; mu_rst_i = pend_data;
            pend_cnt = 0;
        end else if (pend_cnt > 1) begin
            pend_cnt--;
        end
        if (mu_v_o && mu_auto) begin
            pend_cnt  = 2;
            pend_uid  = mu_uid_o;
            pend_rd   = mu_rd_o;
            pend_data = mu_calc(mu_op_o, mu_rs1_o, mu_rs2_o);
        end
    end

    always @(negedge clk) begin
        #1;
        if (mu_v_o) begin
            issue_cnt++;
            iss_op_q.push_back(mu_op_o);
            iss_cyc_q.push_back(cyc);
        end
        if (mu_we_i) res_cyc_q.push_back(cyc);
        if (wb_valid_o && wb_ready_i) begin
            wbu_q.push_back(wb_uid_o);
            wbd_q.push_back(wb_data_o);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_logs();
        iss_op_q.delete(); iss_cyc_q.delete(); res_cyc_q.delete();
        wbu_q.delete(); wbd_q.delete();
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] uid, input logic [RW-1:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
        in_valid_i = 1'b1; in_op_i = op; in_uid_i = uid; in_rd_i = rd;
        in_rs1_i = a; in_rs2_i = b;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic inject(input logic [7:0] uid, input logic [RW-1:0] rd, input logic [31:0] d);
        inj_uid = uid; inj_rd = rd; inj_data = d; inj_req = 1'b1;
    endtask

    task automatic wait_mu_v(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mu_v_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ticks(2);
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        checks++; if (mu_v_o !== 1'b0) begin errors++; $display("FAIL reset_mu_v: got %b want 0", mu_v_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
        checks++; if ({busy_o, err_o} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b want 00", {busy_o, err_o}); end
        resetn = 1'b1;
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready_o); end
    endtask

    task automatic test_single_mul();
        mu_auto = 1'b1; wb_ready_i = 1'b0;
        push(8'h80, 8'h11, 5'd5, 32'd7, 32'd6);
        checks++; if (mu_v_o !== 1'b0) begin errors++; $display("FAIL mul_decide_cycle: got mu_v %b want 0", mu_v_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b want 1", busy_o); end
        tick();
        checks++; if (mu_v_o !== 1'b1) begin errors++; $display("FAIL mul_issue: got mu_v %b want 1", mu_v_o); end
        checks++; if ({mu_op_o, mu_uid_o} !== {8'h80, 8'h11}) begin errors++; $display("FAIL mul_issue_fields: got %h want 8011", {mu_op_o, mu_uid_o}); end
        checks++; if ({mu_rd_o, mu_rs1_o, mu_rs2_o} !== {5'd5, 32'd7, 32'd6}) begin errors++; $display("FAIL mul_issue_ops: got rd %0d rs1 %0d rs2 %0d want 5 7 6", mu_rd_o, mu_rs1_o, mu_rs2_o); end
        tick();
        checks++; if (mu_v_o !== 1'b0) begin errors++; $display("FAIL mul_issue_pulse: got mu_v %b want 0", mu_v_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mul_wb_early: got %b want 0", wb_valid_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL mul_wb_valid: got %b want 1", wb_valid_o); end
        checks++; if ({wb_uid_o, wb_rd_o, wb_data_o} !== {8'h11, 5'd5, 32'd42}) begin errors++; $display("FAIL mul_wb_data: got uid %h rd %0d data %0d want 11 5 42", wb_uid_o, wb_rd_o, wb_data_o); end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        checks++; if ({wb_valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL mul_drained: got valid/busy %b want 00", {wb_valid_o, busy_o}); end
    endtask

    task automatic test_back_to_back();
        clear_logs(); mu_auto = 1'b1; wb_ready_i = 1'b1;
        push(8'h80, 8'h31, 5'd1, 32'd2, 32'd3);
        push(8'h80, 8'h32, 5'd2, 32'd4, 32'd5);
        ticks(20);
        checks++;
        if (iss_cyc_q.size() != 2) begin
            errors++; $display("FAIL b2b_issue_count: got %0d want 2", iss_cyc_q.size());
        end else if (iss_cyc_q[1] - iss_cyc_q[0] != 4) begin
            errors++; $display("FAIL b2b_spacing: got %0d want 4", iss_cyc_q[1] - iss_cyc_q[0]);
        end
        checks++;
        if (wbd_q.size() != 2 || wbd_q[0] !== 32'd6 || wbd_q[1] !== 32'd20) begin
            errors++; $display("FAIL b2b_wb_data: got %0d results want 6 then 20", wbd_q.size());
        end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_div_serial();
        clear_logs(); mu_auto = 1'b1; wb_ready_i = 1'b1;
        push(8'h04, 8'h21, 5'd1, 32'd100, 32'd7);
        push(8'h80, 8'h22, 5'd2, 32'd3, 32'd3);
        ticks(25);
        checks++;
        if (iss_op_q.size() != 2 || res_cyc_q.size() != 2) begin
            errors++; $display("FAIL div_counts: got %0d issues %0d results want 2 2", iss_op_q.size(), res_cyc_q.size());
        end else begin
            checks++; if ({iss_op_q[0], iss_op_q[1]} !== 16'h0480) begin errors++; $display("FAIL div_issue_order: got %h want 0480", {iss_op_q[0], iss_op_q[1]}); end
            checks++; if (iss_cyc_q[1] - res_cyc_q[0] != 2) begin errors++; $display("FAIL div_serialize: got mul issue %0d cycles after div result want 2", iss_cyc_q[1] - res_cyc_q[0]); end
        end
        checks++;
        if (wbd_q.size() != 2) begin
            errors++; $display("FAIL div_wb_count: got %0d want 2", wbd_q.size());
        end else if ({wbu_q[0], wbd_q[0], wbu_q[1], wbd_q[1]} !== {8'h21, 32'd14, 8'h22, 32'd9}) begin
            errors++; $display("FAIL div_wb_order: got %h/%0d %h/%0d want 21/14 22/9", wbu_q[0], wbd_q[0], wbu_q[1], wbd_q[1]);
        end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int base;
        clear_logs(); mu_auto = 1'b1; wb_ready_i = 1'b0;
        base = issue_cnt;
        for (int i = 0; i < 4; i++) push(8'h80, 8'h41 + 8'(i), 5'(i + 1), 32'(i + 1), 32'd10);
        ticks(24);
        checks++; if (issue_cnt - base != 2) begin errors++; $display("FAIL bp_issue_stall: got %0d issues want 2", issue_cnt - base); end
        checks++; if (res_cyc_q.size() != 2) begin errors++; $display("FAIL bp_results: got %0d want 2", res_cyc_q.size()); end
        checks++; if ({wb_valid_o, wb_uid_o, busy_o} !== {1'b1, 8'h41, 1'b1}) begin errors++; $display("FAIL bp_head: got valid %b uid %h busy %b want 1 41 1", wb_valid_o, wb_uid_o, busy_o); end
        wb_ready_i = 1'b1;
        ticks(30);
        checks++; if (issue_cnt - base != 4) begin errors++; $display("FAIL bp_release_issue: got %0d want 4", issue_cnt - base); end
        checks++;
        if (wbu_q.size() != 4) begin
            errors++; $display("FAIL bp_wb_count: got %0d want 4", wbu_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({wbu_q[i], wbd_q[i]} !== {8'h41 + 8'(i), 32'((i + 1) * 10)}) begin
                    errors++; $display("FAIL bp_wb_order[%0d]: got %h/%0d want %h/%0d", i, wbu_q[i], wbd_q[i], 8'h41 + 8'(i), (i + 1) * 10);
                end
            end
        end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_queue_full_flush();
        int base;
        clear_logs(); mu_auto = 1'b0; wb_ready_i = 1'b1;
        base = issue_cnt;
        push(8'h80, 8'h50, 5'd3, 32'd1, 32'd1);
        ticks(3);
        for (int i = 0; i < 4; i++) push(8'h40, 8'h51 + 8'(i), 5'd4, 32'd1, 32'd1);
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL qf_full: got in_ready %b want 0", in_ready_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL qf_flush_ready: got %b want 1", in_ready_o); end
        flush_i = 1'b1; in_valid_i = 1'b1; in_op_i = 8'h80; in_uid_i = 8'h55;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        inject(8'h50, 5'd3, 32'h1234);
        ticks(2);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL qf_idle_empty: got busy %b want 0", busy_o); end
        ticks(3);
        checks++;
        if (wbu_q.size() != 1 || wbu_q[0] !== 8'h50 || wbd_q[0] !== 32'h1234) begin
            errors++; $display("FAIL qf_outstanding_done: got %0d results want uid 50 data 1234", wbu_q.size());
        end
        checks++; if (issue_cnt - base != 1) begin errors++; $display("FAIL qf_no_reissue: got %0d issues want 1", issue_cnt - base); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_errors();
        bit seen;
        int n;
        mu_auto = 1'b0; wb_ready_i = 1'b0;
        push(8'h03, 8'h01, 5'd1, 32'd1, 32'd1);
        checks++; if ({err_o, busy_o} !== 2'b10) begin errors++; $display("FAIL badop_err: got err/busy %b want 10", {err_o, busy_o}); end
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL badop_pulse: got %b want 0", err_o); end

        push(8'h80, 8'h11, 5'd5, 32'd1, 32'd1);
        wait_mu_v(seen);
        checks++; if (!seen) begin errors++; $display("FAIL mm_issue: got no mu_v want issue"); end
        inject(8'h22, 5'd9, 32'hdead);
        ticks(2);
        checks++; if ({err_o, wb_valid_o, busy_o} !== 3'b101) begin errors++; $display("FAIL mm_err: got err/wb/busy %b want 101", {err_o, wb_valid_o, busy_o}); end
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mm_pulse: got %b want 0", err_o); end
        inject(8'h11, 5'd5, 32'd77);
        ticks(2);
        checks++; if ({wb_valid_o, wb_uid_o, wb_data_o, err_o} !== {1'b1, 8'h11, 32'd77, 1'b0}) begin errors++; $display("FAIL mm_still_waiting: got valid %b uid %h data %0d err %b want 1 11 77 0", wb_valid_o, wb_uid_o, wb_data_o, err_o); end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;

        push(8'h80, 8'h33, 5'd6, 32'd1, 32'd1);
        wait_mu_v(seen);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (err_o) begin
                n = i;
                break;
            end
        end
        checks++; if (n < 63 || n > 66) begin errors++; $display("FAIL timeout_err: got err after %0d cycles want 63..66", n); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy %b want 0", busy_o); end
        tick();
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        mu_auto = 1'b0; wb_ready_i = 1'b0;
        push(8'h04, 8'h60, 5'd7, 32'd100, 32'd7);
        push(8'h80, 8'h61, 5'd8, 32'd2, 32'd2);
        wait_mu_v(seen);
        ticks(3);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++; if ({mu_v_o, mu_op_o, mu_uid_o, mu_rd_o} !== '0) begin errors++; $display("FAIL rst_mu_outputs: got v %b op %h uid %h rd %0d want 0", mu_v_o, mu_op_o, mu_uid_o, mu_rd_o); end
        checks++; if ({mu_rs1_o, mu_rs2_o} !== 64'h0) begin errors++; $display("FAIL rst_mu_operands: got %h want 0", {mu_rs1_o, mu_rs2_o}); end
        checks++; if ({wb_valid_o, wb_uid_o, wb_data_o, busy_o, err_o} !== '0) begin errors++; $display("FAIL rst_wb_busy: got valid %b busy %b err %b want 0", wb_valid_o, busy_o, err_o); end
        tick();
        checks++; if ({mu_v_o, busy_o} !== 2'b00) begin errors++; $display("FAIL rst_queue_empty: got mu_v/busy %b want 00", {mu_v_o, busy_o}); end
        inject(8'h60, 5'd7, 32'd14);
        ticks(2);
        checks++; if ({err_o, wb_valid_o} !== 2'b10) begin errors++; $display("FAIL rst_stale_result: got err/wb %b want 10", {err_o, wb_valid_o}); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
        in_op_i = '0; in_uid_i = '0; in_rd_i = '0; in_rs1_i = '0; in_rs2_i = '0;
        mu_we_i = 1'b0; mu_uid_i = '0; mu_rst_i = '0; mu_dst_i = '0;
        test_reset();
        test_single_mul();
        test_back_to_back();
        test_div_serial();
        test_backpressure();
        test_queue_full_flush();
        test_errors();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
